// File: rtl/timer_bcd.sv
// Binary-to-BCD converter for a 16-bit timer count: shift-and-add-3 over 16 cycles,
// a ready/valid output handshake, and a one-entry pending buffer for samples that arrive while busy.
module timer_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] t_in,
    input  logic        t_valid_in,
    output logic [19:0] bcd_out,
    output logic        bcd_valid,
    input  logic        bcd_ready,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]  state;
    logic [15:0] bin_q;
    logic [19:0] acc_q;
    logic [4:0]  step_q;
    logic [15:0] pend_val;
    logic        pend_flag;

    logic [19:0] acc_adj;
    logic [19:0] acc_next;

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_next = {acc_adj[18:0], bin_q[15]};
    end

    assign busy = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (t_valid_in) begin
                        bin_q  <= t_in;
                        acc_q  <= '0;
                        step_q <= 5'd16;
                        state  <= ST_CONV;
                    end
                end

                ST_CONV: begin
                    acc_q  <= acc_next;
                    bin_q  <= {bin_q[14:0], 1'b0};
                    step_q <= step_q - 5'd1;
                    if (step_q == 5'd1) begin
                        bcd_out   <= acc_next;
                        bcd_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                    if (t_valid_in) begin
                        pend_val  <= t_in;
                        pend_flag <= 1'b1;
                        if (pend_flag) overrun <= 1'b1;
                    end
                end

                ST_OUT: begin
                    if (bcd_ready) begin
                        // Handshake: restart directly from here, live input beats the buffered one.
                        bcd_valid <= 1'b0;
                        pend_flag <= 1'b0;
                        if (t_valid_in) begin
                            bin_q  <= t_in;
                            acc_q  <= '0;
                            step_q <= 5'd16;
                            state  <= ST_CONV;
                            if (pend_flag) overrun <= 1'b1;
                        end else if (pend_flag) begin
                            bin_q  <= pend_val;
                            acc_q  <= '0;
                            step_q <= 5'd16;
                            state  <= ST_CONV;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (t_valid_in) begin
                        pend_val  <= t_in;
                        pend_flag <= 1'b1;
                        if (pend_flag) overrun <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bcd.sv
// Directed bench for timer_bcd: conversions, boundaries, backpressure, pending/overrun and reset abort.
module tb_timer_bcd;

    logic        clock;
    logic        reset;
    logic [15:0] t_in;
    logic        t_valid_in;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        bcd_ready;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    timer_bcd dut (
        .clock      (clock),
        .reset      (reset),
        .t_in       (t_in),
        .t_valid_in (t_valid_in),
        .bcd_out    (bcd_out),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts negedges until bcd_valid; n is the number of edges since the capture edge.
    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!bcd_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v, input logic [19:0] exp);
        int n;
        @(negedge clock);
        t_in = v; t_valid_in = 1'b1; bcd_ready = 1'b1;
        @(negedge clock);
        t_valid_in = 1'b0;
        wait_valid(0, n);
        check({tag, "_lat"}, n, 16);
        check({tag, "_out"}, {12'd0, bcd_out}, {12'd0, exp});
        @(negedge clock);
        check({tag, "_vld_drop"}, {31'd0, bcd_valid}, 0);
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic pulse_reset;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int holds_bad;
        logic seen;
        reset = 1'b0; t_in = '0; t_valid_in = 1'b0; bcd_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out", {12'd0, bcd_out}, 0);
        check("rst_vld", {31'd0, bcd_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ovr", {31'd0, overrun}, 0);
        reset = 1'b1;

        run_conv("basic", 16'd1234, 20'h01234);
        run_conv("zero", 16'd0, 20'h00000);
        run_conv("max", 16'd65535, 20'h65535);
        run_conv("n9999", 16'd9999, 20'h09999);
        run_conv("n10000", 16'd10000, 20'h10000);
        check("idle_hold", {12'd0, bcd_out}, 32'h10000);

        // Backpressure
        @(negedge clock);
        t_in = 16'd42; t_valid_in = 1'b1; bcd_ready = 1'b0;
        @(negedge clock);
        t_valid_in = 1'b0;
        wait_valid(0, n);
        check("bp_lat", n, 16);
        holds_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bcd_valid !== 1'b1 || bcd_out !== 20'h00042) holds_bad++;
        end
        check("bp_hold", holds_bad, 0);
        check("bp_out", {12'd0, bcd_out}, 32'h00042);
        bcd_ready = 1'b1;
        @(negedge clock);
        check("bp_release", {31'd0, bcd_valid}, 0);
        check("bp_idle", {31'd0, busy}, 0);

        // Pending overwrite: 7 then 9 during conversion of 5
        check("pend_ovr_pre", {31'd0, overrun}, 0);
        @(negedge clock);
        t_in = 16'd5; t_valid_in = 1'b1; bcd_ready = 1'b1;
        @(negedge clock);
        t_in = 16'd7;
        @(negedge clock);
        t_in = 16'd9;
        @(negedge clock);
        t_valid_in = 1'b0;
        wait_valid(2, n);
        check("pend_lat1", n, 16);
        check("pend_out1", {12'd0, bcd_out}, 32'h00005);
        @(negedge clock);
        check("pend_vld_drop", {31'd0, bcd_valid}, 0);
        check("pend_busy", {31'd0, busy}, 1);
        wait_valid(0, n);
        check("pend_lat2", n, 16);
        check("pend_out2", {12'd0, bcd_out}, 32'h00009);
        check("pend_ovr", {31'd0, overrun}, 1);
        @(negedge clock);
        check("pend_idle", {31'd0, busy}, 0);

        // Simultaneous live input and pending value on the handshake edge
        pulse_reset();
        check("sim_ovr_clr", {31'd0, overrun}, 0);
        @(negedge clock);
        t_in = 16'd50; t_valid_in = 1'b1; bcd_ready = 1'b0;
        @(negedge clock);
        t_in = 16'd100;
        @(negedge clock);
        t_valid_in = 1'b0;
        wait_valid(1, n);
        check("sim_lat1", n, 16);
        check("sim_out1", {12'd0, bcd_out}, 32'h00050);
        check("sim_ovr_pre", {31'd0, overrun}, 0);
        t_in = 16'd200; t_valid_in = 1'b1; bcd_ready = 1'b1;
        @(negedge clock);
        t_valid_in = 1'b0;
        check("sim_vld_drop", {31'd0, bcd_valid}, 0);
        check("sim_ovr", {31'd0, overrun}, 1);
        wait_valid(0, n);
        check("sim_lat2", n, 16);
        check("sim_out2", {12'd0, bcd_out}, 32'h00200);
        @(negedge clock);
        check("sim_idle", {31'd0, busy}, 0);

        // Reset in the middle of a conversion
        @(negedge clock);
        t_in = 16'd1234; t_valid_in = 1'b1; bcd_ready = 1'b1;
        @(negedge clock);
        t_valid_in = 1'b0;
        repeat (7) @(negedge clock);
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_out", {12'd0, bcd_out}, 0);
        check("mid_vld", {31'd0, bcd_valid}, 0);
        check("mid_busy_rst", {31'd0, busy}, 0);
        check("mid_ovr", {31'd0, overrun}, 0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bcd_valid || busy) seen = 1'b1;
        end
        check("mid_no_vld", {31'd0, seen}, 0);
        run_conv("after_rst", 16'd77, 20'h00077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/timer_bcd.md
TIMER_BCD -- requirements
Module: timer_bcd

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port t_in, input, 16 bits: binary count from the upstream timer (its t_out).
REQ-004 SHALL have port t_valid_in, input, 1 bit: t_in is valid this cycle (the upstream t_valid).
REQ-005 SHALL have port bcd_out, output, 20 bits: five BCD digits, where [19:16] is the ten-thousands digit and [3:0] is the units digit.
REQ-006 SHALL have port bcd_valid, output, 1 bit: bcd_out holds a completed conversion.
REQ-007 SHALL have port bcd_ready, input, 1 bit: the downstream consumer accepts bcd_out.
REQ-008 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-009 SHALL have port overrun, output, 1 bit: sticky flag, set when an input sample is discarded.

Function
REQ-010 SHALL implement exactly three states: IDLE, CONV and OUT.
REQ-011 In IDLE with t_valid_in=1 at an edge, SHALL capture t_in into the 16-bit shift register, clear the 20-bit BCD accumulator, load the step counter with 16 and enter CONV.
REQ-012 In IDLE with t_valid_in=0, SHALL remain in IDLE; bcd_out SHALL keep its last value.
REQ-013 Each CONV edge SHALL first add 3 to every accumulator digit >=5, then shift {accumulator, binary register} left by one, then decrement the step counter.
REQ-014 On the CONV edge that decrements the step counter from 1 to 0, SHALL load bcd_out with the final accumulator, enter OUT and assert bcd_valid.
REQ-015 Latency: bcd_valid SHALL be high in the cycle after the 16th edge following the capture edge, i.e. exactly 16 cycles after capture.
REQ-016 In OUT, SHALL hold bcd_valid=1 and bcd_out stable until an edge with bcd_ready=1 (the handshake edge).
REQ-017 bcd_ready SHALL be ignored when bcd_valid=0.
REQ-018 SHALL provide a one-entry pending buffer (16-bit value plus flag) that stores t_in when t_valid_in=1 in CONV or OUT on a non-handshake edge.
REQ-019 A write to an already-full pending buffer SHALL overwrite it (latest value wins) and set overrun.
REQ-020 On the handshake edge, if t_valid_in=1, SHALL start CONV with t_in; if the pending flag is also set, SHALL discard the pending value and set overrun.
REQ-021 On the handshake edge, if t_valid_in=0 and the pending flag is set, SHALL start CONV with the pending value.
REQ-022 On the handshake edge, if neither t_valid_in nor the pending flag is set, SHALL return to IDLE.
REQ-023 The handshake edge SHALL clear bcd_valid and the pending flag in every case (REQ-020 to REQ-022).
REQ-024 A conversion start from OUT SHALL begin on the handshake edge itself, with no IDLE bubble.
REQ-025 overrun SHALL be cleared only by reset.
REQ-026 Every legal input value 0..65535 SHALL convert exactly; every digit of bcd_out SHALL be <=9.

Reset
REQ-027 While reset=0, SHALL force: state IDLE, bcd_out=0, bcd_valid=0, busy=0, overrun=0, pending flag=0, step counter=0, shift registers=0.
REQ-028 Reset asserted mid-CONV or mid-OUT SHALL abort immediately; no bcd_valid pulse SHALL follow.
REQ-029 After reset deasserts, the first t_valid_in=1 edge SHALL be treated per REQ-011.

Verification
REQ-030 Basic: t_in=1234 pulsed 1 cycle, bcd_ready=1 -> 16 cycles later bcd_out=0x01234, bcd_valid=1 for 1 cycle, then busy=0.
REQ-031 Boundaries: t_in=0 -> 0x00000; t_in=65535 -> 0x65535; t_in=9999 -> 0x09999; t_in=10000 -> 0x10000.
REQ-032 Backpressure: t_in=42 with bcd_ready=0 for 30 cycles -> bcd_valid and bcd_out=0x00042 held stable; released on the first bcd_ready=1 edge.
REQ-033 Pending/overrun: t_in=5, then 7 and 9 during CONV, bcd_ready=1 -> outputs 0x00005 then 0x00009; overrun=1.
REQ-034 Simultaneous: pending=100 and t_valid_in=1 with t_in=200 on the handshake edge -> next output is 0x00200; overrun=1.
REQ-035 Reset mid-conversion: reset=0 for 1 cycle at step 8 -> all outputs 0, no bcd_valid; a following t_in=77 yields 0x00077.
